// File: rtl/ps2_key_pkg.sv
// rtl/ps2_key_pkg.sv - shared constants, state type and parity helper for the PS/2 key front end
package ps2_key_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    localparam int KEY_TOG = 10;
    localparam int KEY_PRS = 9;
    localparam int KEY_EXT = 8;

    // Bytes swallowed after E1 in the Pause/Break make sequence
    localparam int PAUSE_SKIP = 7;

    typedef enum logic {IDLE, RECV} ps2_state_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_if.sv
// rtl/ps2_key_if.sv - PS/2 pin inputs and key event outputs grouped as one bundle
interface ps2_key_if;
    logic        ps2_clk_in;
    logic        ps2_dat_in;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    modport master (
        output ps2_clk_in,
        output ps2_dat_in,
        input  ps2_key,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  ps2_clk_in,
        input  ps2_dat_in,
        output ps2_key,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/ps2_filter.sv
// rtl/ps2_filter.sv - pin synchronisers plus ps2_clk glitch filter producing a fall strobe
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clk_in,
    input  logic dat_in,
    output logic fall,
    output logic dat
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          filt_clk;
    logic [CW-1:0] run_cnt;
    logic          fall_q;

    // run_cnt counts consecutive samples that disagree with the filtered level
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt_clk <= 1'b1;
            run_cnt  <= '0;
            fall_q   <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], clk_in};
            dat_sync <= {dat_sync[0], dat_in};
            fall_q   <= 1'b0;
            if (clk_sync[1] == filt_clk) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                run_cnt  <= '0;
                fall_q   <= filt_clk;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    assign fall = fall_q;
    assign dat  = dat_sync[1];

endmodule

// File: rtl/ps2_key_gen.sv
// rtl/ps2_key_gen.sv - PS/2 frame receiver and ps2_key event generator; optional PS2_KEY_PAUSE_SEQ_EN
module ps2_key_gen
    import ps2_key_pkg::*;
#(
    parameter int CLK_MHZ    = 49,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 100
) (
    input logic   clk_sys,
    input logic   reset,
    ps2_key_if.slave ps2
);
    localparam int TO_CYC = CLK_MHZ * TIMEOUT_US;
    localparam int WW     = $clog2(TO_CYC + 1);

    ps2_state_t  state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [WW-1:0] wd;
    logic        fall;
    logic        dat;
    logic        timeout;
    logic [7:0]  shreg;
    logic        par;
    logic        ext_f;
    logic        rel_f;
    logic [10:0] key_q;
    logic        frame_err_q;
    logic        byte_ok;
`ifdef PS2_KEY_PAUSE_SEQ_EN
    logic [2:0]  skip;
`endif

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clk_in  (ps2.ps2_clk_in),
        .dat_in  (ps2.ps2_dat_in),
        .fall    (fall),
        .dat     (dat)
    );

    assign timeout = (state == RECV) && (wd == WW'(TO_CYC - 1));
    assign byte_ok = odd_parity_ok(shreg, par) && dat;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Expiry is checked first so a coincident fall is dropped
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (timeout) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat) begin
                        state_n = RECV;
                        cnt_n   = 4'd1;
                    end
                end
                RECV: begin
                    if (cnt == 4'd10) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wd <= '0;
        end else if (state == RECV && !fall && !timeout) begin
            wd <= wd + 1'b1;
        end else begin
            wd <= '0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            par         <= 1'b0;
            ext_f       <= 1'b0;
            rel_f       <= 1'b0;
            key_q       <= '0;
            frame_err_q <= 1'b0;
`ifdef PS2_KEY_PAUSE_SEQ_EN
            skip        <= '0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            if (timeout) begin
                frame_err_q <= 1'b1;
                ext_f       <= 1'b0;
                rel_f       <= 1'b0;
`ifdef PS2_KEY_PAUSE_SEQ_EN
                skip        <= '0;
`endif
            end else if (fall && state == RECV) begin
                if (cnt <= 4'd8) begin
                    shreg <= {dat, shreg[7:1]};
                end else if (cnt == 4'd9) begin
                    par <= dat;
                end else if (!byte_ok) begin
                    frame_err_q <= 1'b1;
                    ext_f       <= 1'b0;
                    rel_f       <= 1'b0;
`ifdef PS2_KEY_PAUSE_SEQ_EN
                    skip        <= '0;
                end else if (skip != 3'd0) begin
                    skip <= skip - 3'd1;
                    if (skip == 3'd1) begin
                        key_q <= {~key_q[KEY_TOG], 1'b1, 1'b1, 8'h77};
                        ext_f <= 1'b0;
                        rel_f <= 1'b0;
                    end
`endif
                end else begin
                    case (shreg)
                        PS2_PFX_EXT: ext_f <= 1'b1;
                        PS2_PFX_REL: rel_f <= 1'b1;
                        PS2_PFX_PAUSE: begin
`ifdef PS2_KEY_PAUSE_SEQ_EN
                            skip <= 3'(PAUSE_SKIP);
`endif
                        end
                        default: begin
                            key_q <= {~key_q[KEY_TOG], ~rel_f, ext_f, shreg};
                            ext_f <= 1'b0;
                            rel_f <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign ps2.ps2_key   = key_q;
    assign ps2.frame_err = frame_err_q;
    assign ps2.busy      = (state == RECV);

endmodule

// File: tb/tb_ps2_key_gen.sv
// tb/tb_ps2_key_gen.sv - directed self-checking bench for ps2_key_gen
module tb_ps2_key_gen;
    import ps2_key_pkg::*;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    ps2_key_if bus();

    ps2_key_gen dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2     (bus)
    );

    always #10 clk_sys = ~clk_sys;

    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   ferr_cnt  = 0;
    int   tog_flips = 0;
    int   t_fall    = 0;
    logic prev_tog  = 1'b0;
    logic busy_mid  = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (bus.ps2_key[KEY_TOG] !== prev_tog) tog_flips++;
        prev_tog = bus.ps2_key[KEY_TOG];
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ps2_bit(input logic d, input bit glitch);
        bus.ps2_dat_in = d;
        wait_cyc(10);
        if (glitch) begin
            bus.ps2_clk_in = 1'b0;
            wait_cyc(5);
            bus.ps2_clk_in = 1'b1;
        end
        wait_cyc(10);
        bus.ps2_clk_in = 1'b0;
        t_fall = cyc;
        wait_cyc(30);
        bus.ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop, input bit glitch);
        ps2_bit(1'b0, 1'b0);
        busy_mid = bus.busy;
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch && (i == 4));
        ps2_bit((~^b) ^ par_flip, 1'b0);
        ps2_bit(stop, 1'b0);
        wait_cyc(20);
    endtask

    task automatic test_reset;
        bus.ps2_clk_in = 1'b1;
        bus.ps2_dat_in = 1'b1;
        reset = 1'b1;
        wait_cyc(5);
        checks++; if (bus.ps2_key !== 11'h000) begin errors++; $display("FAIL reset_key: got %h expected 000", bus.ps2_key); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.frame_err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        reset = 1'b0;
        wait_cyc(5);
        checks++; if (bus.ps2_key !== 11'h000) begin errors++; $display("FAIL post_reset_key: got %h expected 000", bus.ps2_key); end
    endtask

    task automatic test_make;
        int f0;
        f0 = tog_flips;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.ps2_key !== 11'h61C) begin errors++; $display("FAIL make_key: got %h expected 61c", bus.ps2_key); end
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL make_busy_mid: got %b expected 1", busy_mid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL make_busy_end: got %b expected 0", bus.busy); end
        checks++; if (tog_flips - f0 !== 1) begin errors++; $display("FAIL make_flips: got %0d expected 1", tog_flips - f0); end
    endtask

    task automatic test_break;
        int f0;
        f0 = tog_flips;
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.ps2_key !== 11'h61C) begin errors++; $display("FAIL break_prefix_key: got %h expected 61c", bus.ps2_key); end
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.ps2_key !== 11'h01C) begin errors++; $display("FAIL break_key: got %h expected 01c", bus.ps2_key); end
        checks++; if (tog_flips - f0 !== 1) begin errors++; $display("FAIL break_flips: got %0d expected 1", tog_flips - f0); end
    endtask

    task automatic test_extended;
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.ps2_key !== 11'h775) begin errors++; $display("FAIL ext_key: got %h expected 775", bus.ps2_key); end
        send_frame(8'h75, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.ps2_key !== 11'h275) begin errors++; $display("FAIL ext_cleared_key: got %h expected 275", bus.ps2_key); end
    endtask

    task automatic test_bad_frame;
        int e0;
        e0 = ferr_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        checks++; if (ferr_cnt - e0 !== 1) begin errors++; $display("FAIL parity_err_cycles: got %0d expected 1", ferr_cnt - e0); end
        checks++; if (bus.ps2_key !== 11'h275) begin errors++; $display("FAIL parity_key_hold: got %h expected 275", bus.ps2_key); end
        send_frame(8'h23, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.ps2_key !== 11'h623) begin errors++; $display("FAIL after_parity_key: got %h expected 623", bus.ps2_key); end
        e0 = ferr_cnt;
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        checks++; if (ferr_cnt - e0 !== 1) begin errors++; $display("FAIL stop_err_cycles: got %0d expected 1", ferr_cnt - e0); end
        send_frame(8'h75, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.ps2_key !== 11'h275) begin errors++; $display("FAIL prefix_cleared_key: got %h expected 275", bus.ps2_key); end
    endtask

    task automatic test_timeout;
        int  e0;
        int  t0;
        int  dt;
        bit  found;
        e0    = ferr_cnt;
        found = 1'b0;
        dt    = 0;
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        t0 = t_fall;
        for (int i = 0; i < 5200 && !found; i++) begin
            wait_cyc(1);
            if (bus.frame_err === 1'b1) begin
                found = 1'b1;
                dt    = cyc - t0;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL timeout_seen: got %b expected 1", found); end
        checks++; if (dt < 4900 || dt > 4925) begin errors++; $display("FAIL timeout_delay: got %0d expected 4900..4925", dt); end
        wait_cyc(5);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", bus.busy); end
        checks++; if (ferr_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err_cycles: got %0d expected 1", ferr_cnt - e0); end
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.ps2_key !== 11'h61C) begin errors++; $display("FAIL after_timeout_key: got %h expected 61c", bus.ps2_key); end
    endtask

    task automatic test_glitch;
        int e0;
        e0 = ferr_cnt;
        send_frame(8'h2B, 1'b0, 1'b1, 1'b1);
        checks++; if (bus.ps2_key !== 11'h22B) begin errors++; $display("FAIL glitch_key: got %h expected 22b", bus.ps2_key); end
        checks++; if (ferr_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_err: got %0d expected 0", ferr_cnt - e0); end
    endtask

    task automatic test_pause;
        int f0;
        f0 = tog_flips;
        send_frame(8'hE1, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.ps2_key !== 11'h22B) begin errors++; $display("FAIL pause_e1_key: got %h expected 22b", bus.ps2_key); end
        send_frame(8'h14, 1'b0, 1'b1, 1'b0);
`ifdef PS2_KEY_PAUSE_SEQ_EN
        checks++; if (bus.ps2_key !== 11'h22B) begin errors++; $display("FAIL pause_14_key: got %h expected 22b", bus.ps2_key); end
`else
        checks++; if (bus.ps2_key !== 11'h614) begin errors++; $display("FAIL pause_14_key: got %h expected 614", bus.ps2_key); end
`endif
        send_frame(8'h77, 1'b0, 1'b1, 1'b0);
        send_frame(8'hE1, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h14, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h77, 1'b0, 1'b1, 1'b0);
`ifdef PS2_KEY_PAUSE_SEQ_EN
        checks++; if (bus.ps2_key !== 11'h777) begin errors++; $display("FAIL pause_final_key: got %h expected 777", bus.ps2_key); end
        checks++; if (tog_flips - f0 !== 1) begin errors++; $display("FAIL pause_flips: got %0d expected 1", tog_flips - f0); end
`else
        checks++; if (bus.ps2_key !== 11'h077) begin errors++; $display("FAIL pause_final_key: got %h expected 077", bus.ps2_key); end
        checks++; if (tog_flips - f0 !== 4) begin errors++; $display("FAIL pause_flips: got %0d expected 4", tog_flips - f0); end
`endif
    endtask

    task automatic test_reset_mid_frame;
        int e0;
        e0 = ferr_cnt;
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", bus.busy); end
        reset = 1'b1;
        wait_cyc(3);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.ps2_key !== 11'h000) begin errors++; $display("FAIL midreset_key: got %h expected 000", bus.ps2_key); end
        reset = 1'b0;
        wait_cyc(10);
        checks++; if (ferr_cnt - e0 !== 0) begin errors++; $display("FAIL midreset_err: got %0d expected 0", ferr_cnt - e0); end
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.ps2_key !== 11'h61C) begin errors++; $display("FAIL midreset_next_key: got %h expected 61c", bus.ps2_key); end
    endtask

    initial begin
        bus.ps2_clk_in = 1'b1;
        bus.ps2_dat_in = 1'b1;
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_bad_frame();
        test_timeout();
        test_glitch();
        test_pause();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
